// File: rtl/btn_press_decoder.sv
// btn_press_decoder: classifies active-low button presses into short, long and auto-repeat events
module btn_press_decoder #(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ni,
    output logic       short_o,
    output logic       long_o,
    output logic       repeat_o,
    output logic       busy_o,
    output logic [7:0] press_count_o
);
    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Press state machine with registered single-cycle event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            short_o       <= 1'b0;
            long_o        <= 1'b0;
            repeat_o      <= 1'b0;
            busy_o        <= 1'b0;
            press_count_o <= '0;
        end else begin
            short_o  <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
            case (state)
                IDLE: if (!btn_ni) begin
                    state  <= PRESS;
                    cnt    <= CNT_W'(1);
                    busy_o <= 1'b1;
                end
                PRESS: if (btn_ni) begin
                    state         <= IDLE;
                    cnt           <= '0;
                    short_o       <= 1'b1;
                    busy_o        <= 1'b0;
                    press_count_o <= press_count_o + 8'd1;
                end else if (cnt == LONG_LAST) begin
                    state         <= HOLD;
                    cnt           <= '0;
                    long_o        <= 1'b1;
                    press_count_o <= press_count_o + 8'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HOLD: if (btn_ni) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end else if (cnt == REP_LAST) begin
                    cnt      <= '0;
                    repeat_o <= REPEAT_EN;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
